adder: RTL and testbench



---
 rtl/adder.sv | 58 +++++
 tb/tb_adder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/adder.sv
// adder: synchronous WIDTH-bit up-counter with clear and increment controls.
// Update priority on each rising edge of aclk: srst, then clr, then inc, else hold.
// Compile-time option: define ADDER_SATURATE_EN to make the counter hold at its
// maximum value instead of wrapping to zero. The default build wraps modulo 2^WIDTH.
module adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             aclk,
    input  logic             srst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_inc_val;
    logic [WIDTH-1:0] w_cnt_next;

    // Incrementer one bit wider than the count; the carry flags the all-ones case.
    assign w_sum   = {1'b0, r_cnt} + (WIDTH + 1)'(1);
    assign w_carry = w_sum[WIDTH];

    // Value taken on an increment: wrap to zero, or hold at max when saturating.
    always_comb begin
        w_inc_val = w_sum[WIDTH-1:0];
        if (w_carry) begin
`ifdef ADDER_SATURATE_EN
            w_inc_val = r_cnt;
`else
            w_inc_val = '0;
`endif
        end
    end

    // Priority mux for the non-reset next state: clear beats increment.
    always_comb begin
        w_cnt_next = r_cnt;
        if (clr) begin
            w_cnt_next = '0;
        end else if (inc) begin
            w_cnt_next = w_inc_val;
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign out = r_cnt;

endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for adder. Two instances (WIDTH=8 and WIDTH=4) share the
// same inputs; the stimulus process pushes the expected post-edge counts into a queue
// and a separate monitor pops and compares one entry after every rising edge.
// The expected WIDTH=4 values follow ADDER_SATURATE_EN when it is defined.
module tb_adder;

    logic       aclk;
    logic       srst;
    logic       clr;
    logic       inc;
    logic [7:0] out8;
    logic [3:0] out4;

    adder #(.WIDTH(8)) u_dut8 (
        .aclk (aclk),
        .srst (srst),
        .clr  (clr),
        .inc  (inc),
        .out  (out8)
    );

    adder #(.WIDTH(4)) u_dut4 (
        .aclk (aclk),
        .srst (srst),
        .clr  (clr),
        .inc  (inc),
        .out  (out4)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic       chk;
        logic [7:0] e8;
        logic [3:0] e4;
        string      nm;
    } exp_t;

    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: value of out after the most recent edge.
    logic [7:0] m8;
    logic [3:0] m4;
    logic       m_valid = 1'b0;

    // Drive one cycle of inputs and record the expected result of that edge.
    task automatic step(input logic s, input logic c, input logic i, input string nm);
        exp_t e;
        @(negedge aclk);
        srst = s;
        clr  = c;
        inc  = i;
        if (s || c) begin
            m8      = 8'd0;
            m4      = 4'd0;
            m_valid = 1'b1;
        end else if (i) begin
`ifdef ADDER_SATURATE_EN
            m8 = (m8 == 8'hFF) ? 8'hFF : m8 + 8'd1;
            m4 = (m4 == 4'hF) ? 4'hF : m4 + 4'd1;
`else
            m8 = m8 + 8'd1;
            m4 = m4 + 4'd1;
`endif
        end
        e.chk = m_valid;
        e.e8  = m8;
        e.e4  = m4;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic s, input logic c, input logic i,
                       input string nm);
        for (int k = 0; k < n; k++) begin
            step(s, c, i, nm);
        end
    endtask

    // Monitor: compare both counters just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    n_total++;
                    if (out8 === e.e8) n_pass++;
                    else $display("FAIL %s w8: got %0d want %0d", e.nm, out8, e.e8);
                    n_total++;
                    if (out4 === e.e4) n_pass++;
                    else $display("FAIL %s w4: got %0d want %0d", e.nm, out4, e.e4);
                end
            end
        end
    end

    initial begin
        srst = 1'b0;
        clr  = 1'b0;
        inc  = 1'b0;

        run(25, 1'b1, 1'b0, 1'b0, "reset");
        run(3,  1'b0, 1'b0, 1'b0, "post_reset_idle");

        step(1'b0, 1'b0, 1'b1, "single_inc");
        run(2,  1'b0, 1'b0, 1'b0, "single_hold");

        step(1'b0, 1'b1, 1'b0, "pre_burst_clr");
        run(10, 1'b0, 1'b0, 1'b1, "burst10");
        step(1'b0, 1'b1, 1'b0, "burst_clr");

        run(5,  1'b0, 1'b0, 1'b1, "to_5");
        step(1'b0, 1'b1, 1'b1, "clr_and_inc");

        run(7,  1'b0, 1'b0, 1'b1, "to_7");
        step(1'b1, 1'b0, 1'b1, "srst_and_inc");

        run(255, 1'b0, 1'b0, 1'b1, "to_255");
        step(1'b0, 1'b0, 1'b1, "wrap");
        run(2,  1'b0, 1'b0, 1'b0, "post_wrap_hold");

        step(1'b0, 1'b1, 1'b0, "pre_sat_clr");
        run(20, 1'b0, 1'b0, 1'b1, "inc20");
        step(1'b0, 1'b1, 1'b0, "sat_clr");
        run(3,  1'b0, 1'b0, 1'b0, "final_idle");

        // Allow the monitor to drain; a stuck queue counts as a failure.
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge aclk);
        end
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
